ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the counterpart of the existing keyboard receiver and shares the same ps2_clk/ps2_data pins through open-drain enables.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) and reports the device acknowledge.
- Runs in the 100 MHz system clock domain. It is instantiated beside the receiver in the top level, and game logic drives its command interface.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles the host holds ps2_clk low before a request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clk cycles from request to final line release (15 ms).
- FILTER_LEN, 8: ps2_clk_in samples that must agree before the filtered clock changes (glitch filter).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-low reset
- tx_valid  in  1  command byte offered
- tx_data  in  8  command byte
- tx_ready  out  1  high in IDLE; a transfer is accepted when tx_valid && tx_ready
- busy  out  1  high from acceptance until done or error
- done  out  1  one-cycle pulse: transfer finished, device acknowledged
- error  out  1  one-cycle pulse: NACK or timeout
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous)
- ps2_data_in  in  1  raw PS/2 data pin level (asynchronous)
- ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE, tx_ready=1, busy=0, done=0, error=0, both oe=0, all counters 0.
- Input conditioning:
  - 2-flop synchronizers on both pin inputs.
  - ps2_clk filtered: the filtered level flips only after FILTER_LEN consecutive equal samples.
  - fall = one-cycle strobe on a filtered 1->0 transition.
- IDLE:
  - On tx_valid && tx_ready, latch tx_data into a shift register.
  - Compute parity = ~^tx_data (odd parity over 9 bits).
  - Go to INHIBIT; tx_ready drops and busy rises on the next cycle.
- INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES. In the last INHIBIT cycle, ps2_data_oe=1 (start bit 0). Then go to REQ.
- REQ: ps2_clk_oe=0, ps2_data_oe=1. Start the timeout counter, bit count=0. Go to SEND.
- SEND: on each fall, increment the bit count and set ps2_data_oe as follows:
  - bit counts 1..8: ps2_data_oe = ~data[count-1], LSB first.
  - count 9: ps2_data_oe = ~parity.
  - count 10: ps2_data_oe = 0 (stop bit released high), then go to ACK.
- ACK: on the next fall, sample the synchronized data. 0 = ACK, go to RELEASE; 1 = NACK, go to FAIL.
- RELEASE: wait until the filtered clock and synchronized data are both high. Then pulse done, go to IDLE.
- FAIL: pulse error, both oe=0, go to IDLE.
- Timeout:
  - From entry to REQ, if the counter reaches TIMEOUT_CYCLES before done, go to FAIL.
  - The timeout wins over a fall occurring in the same cycle.
- Lines are never driven high. Outside INHIBIT/REQ/SEND both oe=0, except that ps2_data_oe stays asserted during SEND as described above.
- A fall in IDLE or INHIBIT is ignored.
- tx_valid while busy is ignored; there is no queue.
- done and error are mutually exclusive and never asserted in the same transfer.
- Reset mid-transfer returns to IDLE within one cycle and releases both lines.
- Receiver interaction: the receiver is not gated by this block. The top level masks receiver output while busy=1.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- When defined: on the first NACK or timeout of a transfer, the block does not pulse error. It restarts from INHIBIT with the latched byte and resets the timeout counter, while busy stays high. A second failure goes to FAIL. A retry counter (1 bit) clears on acceptance.
- When undefined: any failure goes straight to FAIL, and no retry logic is synthesized.

Test Plan:
- Send 0xED with a device model acking -> ps2_clk_oe high for exactly INHIBIT_CYCLES. Serial bits after start 0: 1,0,1,1,0,1,1,1, parity 1, stop 1. done pulses once after both lines are high. error never asserts.
- Send 0xF4 -> parity bit 0. Send 0x00 -> parity bit 1. In both cases data_oe is never 1 during the stop-bit period.
- Device model NACKs (data high at the 11th fall) with the macro undefined -> error pulses one cycle, no done, tx_ready=1 the following cycle. With the macro defined -> a second INHIBIT occurs; acking then gives done.
- Device never clocks, with TIMEOUT_CYCLES=2000 -> error pulses 2000 cycles after REQ entry, both oe=0.
- Inject 3-cycle glitches on ps2_clk_in during SEND with FILTER_LEN=8 -> bit count unchanged and the transmitted frame is identical to the clean run.
- Assert rst=0 during bit 4 of SEND -> on the next edge both oe=0, state IDLE, tx_ready=1, and neither done nor error pulses.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit clocked frame, device ACK check.
// Define PS2_TX_RETRY_EN to retry a transfer once after a NACK or timeout before reporting error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic             START_AT_ENTRY = (INHIBIT_CYCLES == 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, FAIL} state_t;

    state_t             state;
    logic [7:0]         shreg;
    logic               parity;
    logic [3:0]         bit_cnt;
    logic [INH_W-1:0]   inh_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               clk_s_p0, clk_s_p1, data_s_p0, data_s_p1;
    logic               clk_filt, fall;
    logic [FLT_W-1:0]   flt_cnt;
    logic               accept, tmo_active, tmo_hit, nack_hit, fail_hit;
`ifdef PS2_TX_RETRY_EN
    logic               retry;
`endif

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    assign accept     = (state == IDLE) && tx_valid && tx_ready;
    assign tmo_active = (state == REQ) || (state == SEND) || (state == ACK) || (state == RELEASE);
    assign tmo_hit    = tmo_active && (tmo_cnt == TMO_LAST);
    assign nack_hit   = (state == ACK) && fall && data_s_p1;
    // Timeout is checked ahead of any fall handled in the same cycle
    assign fail_hit   = tmo_hit || nack_hit;

    // Stage p0/p1: pin synchronizers, then a run-length glitch filter on the clock
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s_p0  <= 1'b1;
            clk_s_p1  <= 1'b1;
            data_s_p0 <= 1'b1;
            data_s_p1 <= 1'b1;
            clk_filt  <= 1'b1;
            flt_cnt   <= '0;
            fall      <= 1'b0;
        end else begin
            clk_s_p0  <= ps2_clk_in;
            clk_s_p1  <= clk_s_p0;
            data_s_p0 <= ps2_data_in;
            data_s_p1 <= data_s_p0;
            fall      <= 1'b0;
            if (clk_s_p1 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_filt <= clk_s_p1;
                flt_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shreg  <= tx_data;
            parity <= odd_parity(tx_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
`ifdef PS2_TX_RETRY_EN
            retry       <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (tmo_active) tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (fail_hit) begin
`ifdef PS2_TX_RETRY_EN
                if (!retry) begin
                    retry       <= 1'b1;
                    state       <= INHIBIT;
                    inh_cnt     <= '0;
                    tmo_cnt     <= '0;
                    ps2_clk_oe  <= 1'b1;
                    ps2_data_oe <= START_AT_ENTRY;
                end else begin
                    state       <= FAIL;
                    error       <= 1'b1;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                end
`else
                state       <= FAIL;
                error       <= 1'b1;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        state       <= INHIBIT;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        inh_cnt     <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= START_AT_ENTRY;
`ifdef PS2_TX_RETRY_EN
                        retry       <= 1'b0;
`endif
                    end
                    INHIBIT: begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                        if (inh_cnt == INH_PRE) ps2_data_oe <= 1'b1;
                        if (inh_cnt == INH_LAST) begin
                            state      <= REQ;
                            ps2_clk_oe <= 1'b0;
                            tmo_cnt    <= '0;
                        end
                    end
                    REQ: begin
                        bit_cnt     <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= SEND;
                    end
                    // bit_cnt holds the number of falls seen so far; the new bit goes out on each fall
                    SEND: if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            ps2_data_oe <= ~shreg[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            ps2_data_oe <= ~parity;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end
                    end
                    ACK: if (fall) state <= RELEASE;
                    RELEASE: if (clk_filt && data_s_p1) begin
                        done     <= 1'b1;
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                    FAIL: begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames, a monitor checks each done/error.
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int TMO  = 2000;
    localparam int FL   = 8;
    localparam int HALF = 25;
    localparam int M_ACK = 0, M_NACK = 1, M_NACK1 = 2, M_SILENT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_in, ps2_data_in;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;

    always #5 clk = ~clk;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    typedef struct {
        string       name;
        logic [10:0] frame;
        bit          chk_frame;
        bit          ok;
        int          inhibits;
        bit          chk_tmo;
        int          inh_base;
    } exp_t;

    exp_t sbq[$];
    int n_checks = 0, n_fail = 0, n_events = 0, cyc = 0;
    int inh_run = 0, inh_len = 0, inh_num = 0, req_cyc = 0;
    logic last_doe = 1'b0, inh_last_doe = 1'b0;
    int mode = M_ACK, fall_count = 0;
    bit glitch_en = 1'b0, dev_abort = 1'b0;
    logic [10:0] dev_frame = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Inhibit tracker: length of each ps2_clk_oe pulse and the cycle the line is released (REQ)
    initial forever begin
        @(negedge clk);
        if (rst && ps2_clk_oe === 1'b1) begin
            inh_run++;
            last_doe = ps2_data_oe;
        end else if (inh_run != 0) begin
            inh_len      = inh_run;
            inh_last_doe = last_doe;
            req_cyc      = cyc;
            inh_num++;
            inh_run      = 0;
        end
    end

    task automatic run_frame();
        logic [10:0] f;
        bit ack;
        ack = (mode == M_ACK);
        if (mode == M_NACK1) mode = M_ACK;
        f = '0;
        f[0] = ps2_data_in;
        fall_count = 0;
        for (int k = 1; k <= 11; k++) begin
            for (int i = 0; i < HALF; i++) begin
                if (k == 11 && ack && i == HALF / 2) dev_data_low = 1'b1;
                if (glitch_en && k >= 2 && k <= 10 && i == 14) glitch = 1'b1;
                if (i == 17) glitch = 1'b0;
                @(negedge clk);
                if (dev_abort) break;
            end
            if (dev_abort) break;
            dev_clk_low = 1'b1;
            fall_count = k;
            for (int i = 0; i < HALF; i++) begin
                @(negedge clk);
                if (dev_abort) break;
            end
            if (dev_abort) break;
            if (k <= 10) f[k] = ps2_data_in;
            if (k == 10) begin
                check("stop_bit_data_oe", ps2_data_oe, 1'b0);
                dev_frame = f;
            end
            dev_clk_low = 1'b0;
        end
        dev_clk_low = 1'b0;
        glitch = 1'b0;
        if (!dev_abort) repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    initial begin : device
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (inh_num != seen) begin
                seen = inh_num;
                if (mode != M_SILENT) run_frame();
            end
        end
    end

    // Monitor: every done/error pulse pops one expectation
    initial begin : monitor
        exp_t e;
        bit chk_next;
        chk_next = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_next) begin
                check("tx_ready_after_pulse", tx_ready, 1'b1);
                check("pulse_one_cycle", done | error, 1'b0);
                chk_next = 1'b0;
            end
            if (rst && (done === 1'b1 || error === 1'b1)) begin
                check("done_error_exclusive", done & error, 1'b0);
                if (sbq.size() == 0) begin
                    check("unexpected_pulse_queue", sbq.size(), 1);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, "_done"}, done, e.ok);
                    check({e.name, "_error"}, error, !e.ok);
                    if (e.chk_frame) check({e.name, "_frame"}, dev_frame, e.frame);
                    check({e.name, "_inhibit_len"}, inh_len, INH);
                    check({e.name, "_start_in_last_inhibit"}, inh_last_doe, 1'b1);
                    check({e.name, "_inhibit_count"}, inh_num - e.inh_base, e.inhibits);
                    if (e.chk_tmo) check({e.name, "_timeout_cycles"}, cyc - req_cyc, TMO);
                    if (error) check({e.name, "_oe_released"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
                end
                n_events++;
                chk_next = 1'b1;
            end
        end
    end

    task automatic run_tx(input string name, input logic [7:0] d, input logic [10:0] frame,
                          input bit chkf, input bit ok, input int md, input bit gl,
                          input int inhibits, input bit chkt, input bit poke, input int limit);
        exp_t e;
        int base;
        mode = md;
        glitch_en = gl;
        dev_frame = '0;
        fall_count = 0;
        e.name = name; e.frame = frame; e.chk_frame = chkf; e.ok = ok;
        e.inhibits = inhibits; e.chk_tmo = chkt; e.inh_base = inh_num;
        sbq.push_back(e);
        base = n_events;
        check({name, "_ready_before"}, tx_ready, 1'b1);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check({name, "_busy_after_accept"}, {busy, tx_ready}, 2'b10);
        for (int i = 0; i < limit && n_events == base; i++) begin
            if (poke) begin
                tx_valid = (i >= 100 && i < 105);
                tx_data = 8'h55;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check({name, "_completed"}, n_events - base, 1);
        if (n_events == base) sbq.delete();
        repeat (40) @(negedge clk);
    endtask

    initial begin : main
        int base;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_clk_oe", ps2_clk_oe, 1'b0);
        check("reset_data_oe", ps2_data_oe, 1'b0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        run_tx("ed_ack",   8'hED, 11'h7DA, 1, 1, M_ACK, 0, 1, 0, 0, 3000);
        run_tx("f4_ack",   8'hF4, 11'h5E8, 1, 1, M_ACK, 0, 1, 0, 1, 3000);
        run_tx("00_ack",   8'h00, 11'h600, 1, 1, M_ACK, 0, 1, 0, 0, 3000);
        run_tx("ff_ack",   8'hFF, 11'h7FE, 1, 1, M_ACK, 0, 1, 0, 0, 3000);
`ifdef PS2_TX_RETRY_EN
        run_tx("nack_retry", 8'hF4, 11'h5E8, 1, 1, M_NACK1, 0, 2, 0, 0, 5000);
        run_tx("timeout",    8'hED, 11'h000, 0, 0, M_SILENT, 0, 2, 1, 0, 8000);
`else
        run_tx("nack",       8'hF4, 11'h5E8, 1, 0, M_NACK, 0, 1, 0, 0, 5000);
        run_tx("timeout",    8'hED, 11'h000, 0, 0, M_SILENT, 0, 1, 1, 0, 8000);
`endif
        run_tx("ed_glitch", 8'hED, 11'h7DA, 1, 1, M_ACK, 1, 1, 0, 0, 3000);

        // Reset in the middle of bit 4
        mode = M_ACK;
        glitch_en = 1'b0;
        fall_count = 0;
        base = n_events;
        tx_data = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 2000 && fall_count < 4; i++) @(negedge clk);
        check("rst_mid_reached_bit4", fall_count, 4);
        repeat (15) @(negedge clk);
        dev_abort = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_mid_data_oe", ps2_data_oe, 1'b0);
        check("rst_mid_tx_ready", tx_ready, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_pulses", {done, error}, 2'b00);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        check("rst_mid_no_done_or_error", n_events - base, 0);
        dev_abort = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
